// File: rtl/power3_stream_ctrl.sv
// Valid/ready wrapper around the fixed-latency, stall-free X^3 core.
// Tracks in-flight samples and buffers results in a first-word-fall-through FIFO sized by credits.
module power3_stream_ctrl #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3,
    parameter int DEPTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] core_x,
    input  logic [WIDTH-1:0] core_pow,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_pow,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(DEPTH + LATENCY + 1) + 1;

    // In-flight tracking: one valid bit and one X tag per core pipeline stage
    logic [LATENCY-1:0] vld_q;
    logic [LATENCY-1:0] vld_d;
    logic [WIDTH-1:0]   tag_q [LATENCY];
    logic [WIDTH-1:0]   tag_d [LATENCY];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic [2*WIDTH-1:0] mem [DEPTH];
    logic [2*WIDTH-1:0] head;

    logic          accept;
    logic          push;
    logic          push_ok;
    logic          pop;
    logic          full;
    logic [SW-1:0] inflight;
    logic [SW-1:0] occupancy;

    assign core_x = in_data;
    assign accept = in_valid & in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign vld_d[gi] = accept;
                assign tag_d[gi] = in_data;
            end else begin : g_tail
                assign vld_d[gi] = vld_q[gi-1];
                assign tag_d[gi] = tag_q[gi-1];
            end
        end
    endgenerate

    // Credits count everything already committed: buffered plus in flight.
    // A pop in the same cycle is deliberately not credited to keep in_ready registered-only.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + SW'(vld_q[i]);
        end
        occupancy = SW'(count_q) + inflight;
    end

    assign in_ready = (occupancy < SW'(DEPTH));

    assign full    = (count_q == CW'(DEPTH));
    assign push    = vld_q[LATENCY-1];
    assign push_ok = push & ~full;

    assign head      = mem[rd_ptr_q];
    assign out_valid = (count_q != '0);
    assign out_x     = head[2*WIDTH-1:WIDTH];
    assign out_pow   = head[WIDTH-1:0];
    assign pop       = out_valid & out_ready;
    assign overflow  = overflow_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push & full) begin
            overflow_d = 1'b1;
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < LATENCY; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            vld_q      <= vld_d;
            tag_q      <= tag_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage carries no reset; validity is governed entirely by count and pointers
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {tag_q[LATENCY-1], core_pow};
        end
    end

endmodule

// File: tb/tb_power3_stream_ctrl.sv
// Bench for power3_stream_ctrl: behavioural core + queue-based reference model,
// per-cycle comparison plus directed scenarios with literal expectations.
module tb_power3_stream_ctrl;

    localparam int WIDTH   = 8;
    localparam int LATENCY = 3;
    localparam int DEPTH   = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] core_x;
    logic [WIDTH-1:0] core_pow;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_pow;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    power3_stream_ctrl #(.WIDTH(WIDTH), .LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .core_x   (core_x),
        .core_pow (core_pow),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x    (out_x),
        .out_pow  (out_pow),
        .overflow (overflow)
    );

    function automatic logic [7:0] cube8(input logic [7:0] v);
        int t;
        t = int'(v) * int'(v) * int'(v);
        return t[7:0];
    endfunction

    // Stand-in for the valid-less core: LATENCY register stages, never reset
    logic [7:0] p1, p2, p3;
    always @(posedge clk) begin
        p1 <= cube8(core_x);
        p2 <= p1;
        p3 <= p2;
    end
    assign core_pow = p3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: every accepted sample is in the queue until popped;
    // it becomes visible at the head LATENCY+1 cycles after acceptance.
    typedef struct {
        logic [7:0] x;
        int         avail;
    } ent_t;
    ent_t q[$];
    int   cyc_n = 0;

    always @(negedge clk) begin
        logic exp_ready;
        logic exp_valid;
        if (rst) begin
            q.delete();
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
            chk("rst_overflow", 32'(overflow), 32'd0);
        end else begin
            exp_ready = (q.size() < DEPTH);
            exp_valid = (q.size() > 0) && (q[0].avail <= cyc_n);
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("overflow", 32'(overflow), 32'd0);
            if (exp_valid) begin
                chk("out_x", 32'(out_x), 32'(q[0].x));
                chk("out_pow", 32'(out_pow), 32'(cube8(q[0].x)));
                if (out_ready) void'(q.pop_front());
            end
            if (in_valid && exp_ready) q.push_back('{in_data, cyc_n + LATENCY + 1});
        end
        cyc_n++;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int got;
        bit found;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        look();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        cyc();
        cyc();
        rst = 1'b0;
        repeat (3) cyc();

        // Single X=3: result exactly LATENCY+1 cycles after acceptance
        in_valid = 1'b1; in_data = 8'd3; out_ready = 1'b1;
        look();
        chk("single_accept", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            look();
            if (k < 4) begin
                chk("single_early_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("single_valid", 32'(out_valid), 32'd1);
                chk("single_x", 32'(out_x), 32'd3);
                chk("single_pow", 32'(out_pow), 32'd27);
            end
            cyc();
        end
        repeat (3) cyc();

        // Back-to-back 7, 16, 255 -> 87, 0, 255 on consecutive cycles
        in_valid = 1'b1; in_data = 8'd7;   cyc();
        in_data = 8'd16;  cyc();
        in_data = 8'd255; cyc();
        in_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            look();
            if (out_valid) found = 1'b1;
            else cyc();
        end
        chk("b2b_found", 32'(found), 32'd1);
        chk("b2b_x0", 32'(out_x), 32'd7);
        chk("b2b_p0", 32'(out_pow), 32'd87);
        cyc(); look();
        chk("b2b_x1", 32'(out_x), 32'd16);
        chk("b2b_p1", 32'(out_pow), 32'd0);
        cyc(); look();
        chk("b2b_x2", 32'(out_x), 32'd255);
        chk("b2b_p2", 32'(out_pow), 32'd255);
        cyc();
        repeat (4) cyc();

        // Full-rate stream X=0..19 with out_ready=1
        got = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            look();
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            if (out_valid && out_ready) got++;
            cyc();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            look();
            if (out_valid && out_ready) got++;
            cyc();
        end
        chk("stream_results", 32'(got), 32'd20);

        // Backpressure: out_ready=0, 12 offers -> exactly DEPTH accepted
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; in_data = 8'(100 + acc);
            look();
            if (in_ready) acc++;
            cyc();
        end
        in_valid = 1'b0;
        chk("full_accepted", 32'(acc), 32'd8);
        repeat (5) cyc();
        look();
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_overflow", 32'(overflow), 32'd0);
        chk("full_head_x", 32'(out_x), 32'd100);
        chk("full_head_pow", 32'(out_pow), 32'(cube8(8'd100)));
        cyc();
        out_ready = 1'b1;
        look();
        chk("pop_valid", 32'(out_valid), 32'd1);
        cyc();
        out_ready = 1'b0;
        look();
        chk("pop_in_ready", 32'(in_ready), 32'd1);
        chk("pop_next_x", 32'(out_x), 32'd101);
        cyc();
        out_ready = 1'b1;
        repeat (12) cyc();

        // Reset with three samples in flight
        in_valid = 1'b1;
        in_data = 8'd40; cyc();
        in_data = 8'd41; cyc();
        in_data = 8'd42; cyc();
        in_valid = 1'b0;
        rst = 1'b1;
        look();
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            look();
            chk("postrst_no_stale", 32'(out_valid), 32'd0);
            cyc();
        end
        look();
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
